// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with a single holding register
// (or an 8-entry FIFO when UART_RX_FIFO_EN is defined); bus responses are registered.
`timescale 1ns/1ps

package uart_rx_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_ready;
  } mem_out_type;

endpackage

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clock_rate = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  uart_in,
  output mem_out_type uart_out,
  output logic        rx_irq,
  input  logic        rx
);

  localparam logic [31:0] HALF_M1 = 32'(clock_rate / 2) - 32'd1;
  localparam logic [31:0] LAST    = 32'(clock_rate - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic        push_q, ferr_q;
  logic [7:0]  push_dat_q;

  logic        ovr_q, frm_q;
  logic        ovr_d, frm_d, ovr_set;
  logic        resp_rdy_q, resp_err_q, irq_q;
  logic [31:0] resp_dat_q;

  logic        rd_req, addr_data, addr_stat, pop_req, stat_rd, pop;
  logic [7:0]  rd_byte;
  logic [3:0]  cur_cnt;
  logic        cur_vld, vld_d;

  logic        unused_wdata;
  assign unused_wdata = ^uart_in.mem_wdata;

  // Receive FSM; push_q/ferr_q are one-cycle pulses towards the storage side.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      push_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_dat_q <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_s_q) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q      <= '0;
            state_q    <= IDLE;
            push_q     <= rx_s_q;
            ferr_q     <= !rx_s_q;
            push_dat_q <= shift_q;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_req    = uart_in.mem_valid && (uart_in.mem_wstrb == 4'd0);
    addr_data = (uart_in.mem_addr == 32'h0);
    addr_stat = (uart_in.mem_addr == 32'h8);
    pop_req   = rd_req && addr_data;
    stat_rd   = rd_req && addr_stat;
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] fcnt_q, fcnt_d;
  logic       accept;

  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  always_comb begin
    pop     = pop_req && (fcnt_q != 4'd0);
    accept  = push_q && ((fcnt_q != 4'd8) || pop);
    ovr_set = push_q && !accept;
    fcnt_d  = fcnt_q + {3'd0, accept} - {3'd0, pop};
    rd_byte = mem_q[rd_ptr_q];
    cur_vld = (fcnt_q != 4'd0);
    cur_cnt = fcnt_q;
    vld_d   = (fcnt_d != 4'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= push_dat_q;
        wr_ptr_q        <= wr_ptr_q + 3'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 3'd1;
      fcnt_q <= fcnt_d;
    end
  end
`else
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_dat_q, hold_dat_d;

  // A byte arriving on the cycle the old one is read replaces it without overrun.
  always_comb begin
    pop        = pop_req && hold_vld_q;
    hold_vld_d = hold_vld_q && !pop;
    hold_dat_d = hold_dat_q;
    ovr_set    = 1'b0;
    if (push_q) begin
      if (hold_vld_q && !pop) begin
        ovr_set = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_dat_d = push_dat_q;
      end
    end
    rd_byte = hold_dat_q;
    cur_vld = hold_vld_q;
    cur_cnt = 4'd0;
    vld_d   = hold_vld_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end
`endif

  always_comb begin
    ovr_d = (ovr_q && !stat_rd) || ovr_set;
    frm_d = (frm_q && !stat_rd) || ferr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
      resp_rdy_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_dat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ovr_q      <= ovr_d;
      frm_q      <= frm_d;
      irq_q      <= vld_d;
      resp_rdy_q <= uart_in.mem_valid;
      resp_err_q <= uart_in.mem_valid && !(addr_data || addr_stat);
      resp_dat_q <= '0;
      if (pop) resp_dat_q <= {24'd0, rd_byte};
      else if (stat_rd) resp_dat_q <= {24'd0, cur_cnt, 1'b0, frm_q, ovr_q, cur_vld};
    end
  end

  assign uart_out.mem_rdata = resp_dat_q;
  assign uart_out.mem_error = resp_err_q;
  assign uart_out.mem_ready = resp_rdy_q;
  assign rx_irq             = irq_q;

endmodule
